qrs_peak_detector: RTL and testbench
====================================

# qrs_peak_detector

Decision stage after the ECG low-pass FIR stage. It takes the filtered ECG samples and their sample strobe and rectifies each sample. A compare-and-track state machine with a refractory period marks each QRS complex with a single-cycle pulse. For each beat it reports the peak magnitude and the R-R interval in samples; the interval feeds the heart-rate logic downstream.

## Interface
Parameters:
- THRESH_INIT, 32'd2000: initial detection threshold (the fixed threshold when adaptation is compiled out).
- THRESH_MIN, 32'd500: floor for the adaptive threshold.
- REFRACT, 50: refractory length in samples (enable strobes) after each detection, ≥1.
- MAX_QRS, 40: maximum samples spent in TRACK before a forced detection, ≥1.
- RR_W, 16: width of the R-R interval counter.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: sample strobe; one new filtered_ecg sample per high cycle.
- filtered_ecg, input, 32 signed: filtered sample from the upstream FIR stage.
- qrs_detect, output, 1: one-clock pulse per detected QRS.
- peak_value, output, 32 unsigned: peak magnitude of the last detected QRS.
- rr_interval, output, RR_W: samples between the last two detections.
- threshold, output, 32 unsigned: current detection threshold.

## Operation
- Rectify: mag = |filtered_ecg|. -2^31 saturates to 2^31-1.
- rr_cnt increments on every enable and saturates at 2^RR_W-1.
- States, advanced only on enable:
  - SEARCH: if mag > threshold, go to TRACK with cur_max = mag and width_cnt = 1.
  - TRACK, while mag > threshold: cur_max = max(cur_max, mag) and width_cnt++.
  - TRACK, detection: triggered when mag ≤ threshold, or when width_cnt reaches MAX_QRS. On detection:
    - qrs_detect pulses.
    - peak_value <= cur_max (including the current mag if that sample is larger).
    - rr_interval <= rr_cnt+1 (saturating), then rr_cnt <= 0.
    - Go to REFRACT with refr_cnt = REFRACT.
  - REFRACT: refr_cnt decrements on each enable. After REFRACT strobes, go to SEARCH. Samples arriving in REFRACT are ignored apart from rr_cnt.
- enable low: all state, counters and outputs hold, except that qrs_detect returns to 0.
- Reset values: state SEARCH, qrs_detect 0, peak_value 0, rr_interval 0, rr_cnt 0, cur_max 0, threshold THRESH_INIT. With adaptation compiled in, spk = 2*THRESH_INIT.

## Timing
- Registered outputs update at the rising edge where enable=1 samples the triggering input.
- qrs_detect is high for exactly one clk cycle after that edge, even if enable stays high.
- Latency from the first sub-threshold sample to qrs_detect is 1 clk.
- A forced detection happens on the MAX_QRS-th TRACK sample.
- The first SEARCH compare happens on the (REFRACT+1)-th strobe after detection.
- A threshold update takes effect from the next enable sample.
- reset overrides enable in the same cycle. Reset in the middle of TRACK or REFRACT goes straight to SEARCH with no pulse.

## Configuration
- QRS_ADAPTIVE_THR_EN defined:
  - On each detection, spk <= spk - (spk>>3) + (peak>>3), using the new peak value.
  - threshold <= max(THRESH_MIN, spk_new>>1).
  - All arithmetic is 32-bit unsigned; no overflow is possible.
- QRS_ADAPTIVE_THR_EN undefined:
  - threshold is constant at THRESH_INIT.
  - No spk register exists.
  - THRESH_MIN is unused.

## Test plan
- Reset: hold reset 3 clks with enable=1 and filtered_ecg=5000 -> all outputs at reset values, no qrs_detect; threshold = 2000.
- Single beat, fixed threshold: samples 0,0,3000,-6000,4000,100 -> qrs_detect on the edge sampling 100; peak_value=6000; rr_interval=6; exactly one pulse.
- Refractory, then second beat: 5000 repeated on the 10 strobes after detection -> no pulse. Later beat at 7000 whose falling sample is 60 strobes after the first detection -> second pulse, rr_interval=60.
- Forced detection: constant 9000 for 45 strobes -> pulse on the 40th TRACK sample, peak_value=9000; no pulse again until 50 refractory strobes pass and a new crossing follows.
- Adaptive (QRS_ADAPTIVE_THR_EN): reset spk=4000; one beat with peak 8000 -> spk=4500, threshold=2250. Repeated peaks of 600 -> threshold settles at THRESH_MIN=500.
- Edge cases:
  - filtered_ecg=-2^31 -> peak_value=2^31-1.
  - enable gapped with idle cycles -> identical results.
  - reset asserted mid-TRACK -> no pulse.

Source files
------------

// File: rtl/qrs_peak_detector.sv
// ---------------------------------------------------------------------------
// qrs_peak_detector
//
// Decision stage that sits behind the ECG low-pass FIR. Each strobed sample
// is rectified and run through a compare-and-track state machine:
//   SEARCH  - wait for the rectified sample to rise above the threshold
//   TRACK   - follow the peak while the signal stays above the threshold
//   REFRACT - ignore samples for a fixed number of strobes after a beat
// Every detected QRS complex produces a one-clock pulse. The peak magnitude
// and the R-R interval (in samples) are reported for that beat.
//
// Optional feature macro: QRS_ADAPTIVE_THR_EN
//   defined   - the threshold tracks a running signal-peak estimate (spk) and
//               is floored at THRESH_MIN
//   undefined - the threshold is the constant THRESH_INIT (no spk register)
//
// Parameters:
//   THRESH_INIT  initial (or fixed) detection threshold
//   THRESH_MIN   floor for the adaptive threshold
//   REFRACT      refractory length in strobes after each detection (>= 1)
//   MAX_QRS      TRACK length in strobes that forces a detection (>= 1)
//   RR_W         width of the R-R interval counter
//
// Ports:
//   clk           single clock, all logic on the rising edge
//   reset         synchronous, active-high
//   enable        sample strobe, one filtered_ecg sample per high cycle
//   filtered_ecg  signed 32-bit filtered sample
//   qrs_detect    one-clock pulse per detected QRS
//   peak_value    peak magnitude of the last detected QRS
//   rr_interval   samples between the last two detections
//   threshold     current detection threshold
// ---------------------------------------------------------------------------
module qrs_peak_detector #(
  parameter logic [31:0] THRESH_INIT = 32'd2000,
  parameter logic [31:0] THRESH_MIN  = 32'd500,
  parameter int          REFRACT     = 50,
  parameter int          MAX_QRS     = 40,
  parameter int          RR_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [31:0] filtered_ecg,
  output logic               qrs_detect,
  output logic [31:0]        peak_value,
  output logic [RR_W-1:0]    rr_interval,
  output logic [31:0]        threshold
);

  localparam int REFR_W = $clog2(REFRACT + 1);
  localparam int WID_W  = $clog2(MAX_QRS + 1);

  localparam logic [REFR_W-1:0] REFR_LOAD = REFR_W'(REFRACT);
  localparam logic [REFR_W-1:0] REFR_ONE  = REFR_W'(1);
  localparam logic [WID_W-1:0]  WID_LIMIT = WID_W'(MAX_QRS);
  localparam logic [WID_W-1:0]  WID_ONE   = WID_W'(1);
  localparam logic [RR_W-1:0]   RR_SAT    = '1;
  localparam logic [RR_W-1:0]   RR_ONE    = RR_W'(1);
  localparam logic [31:0]       MAG_SAT   = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         cur_max_q, cur_max_d;
  logic [WID_W-1:0]    width_q, width_d;
  logic [REFR_W-1:0]   refr_q, refr_d;
  logic [RR_W-1:0]     rr_cnt_q, rr_cnt_d;
  logic [31:0]         peak_q, peak_d;
  logic [RR_W-1:0]     rr_int_q, rr_int_d;
  logic                detect_q, detect_d;

  logic [31:0]         mag;
  logic [31:0]         thr_cur;
  logic [31:0]         track_peak;
  logic [WID_W-1:0]    width_inc;
  logic [RR_W-1:0]     rr_inc;

  // Rectifier. The most negative input has no positive twin in 32 bits, so it
  // is pinned to the largest positive magnitude instead of wrapping to itself.
  always_comb begin
    mag = 32'd0;
    if (filtered_ecg == 32'sh8000_0000) begin
      mag = MAG_SAT;
    end else if (filtered_ecg[31]) begin
      mag = $unsigned(-filtered_ecg);
    end else begin
      mag = $unsigned(filtered_ecg);
    end
  end

  // Helper values shared by the state machine and the threshold adaptation.
  // track_peak is the beat peak if this sample were to end the beat, so the
  // sample that closes a forced detection still contributes its magnitude.
  always_comb begin
    track_peak = (mag > cur_max_q) ? mag : cur_max_q;
    width_inc  = width_q + WID_ONE;
    rr_inc     = (rr_cnt_q == RR_SAT) ? RR_SAT : (rr_cnt_q + RR_ONE);
  end

  // Next-state and next-output logic. Nothing moves unless enable is high,
  // except that the detect pulse always falls back to zero so it lasts exactly
  // one clock even with back-to-back strobes.
  always_comb begin
    state_d   = state_q;
    cur_max_d = cur_max_q;
    width_d   = width_q;
    refr_d    = refr_q;
    rr_cnt_d  = rr_cnt_q;
    peak_d    = peak_q;
    rr_int_d  = rr_int_q;
    detect_d  = 1'b0;

    if (enable) begin
      rr_cnt_d = rr_inc;

      case (state_q)
        ST_SEARCH: begin
          if (mag > thr_cur) begin
            state_d   = ST_TRACK;
            cur_max_d = mag;
            width_d   = WID_ONE;
          end
        end

        ST_TRACK: begin
          // The beat ends when the signal drops back to the threshold or when
          // this sample would make the complex MAX_QRS samples wide.
          if ((mag <= thr_cur) || (width_inc >= WID_LIMIT)) begin
            detect_d  = 1'b1;
            peak_d    = track_peak;
            cur_max_d = track_peak;
            rr_int_d  = rr_inc;
            rr_cnt_d  = '0;
            width_d   = '0;
            refr_d    = REFR_LOAD;
            state_d   = ST_REFRACT;
          end else begin
            cur_max_d = track_peak;
            width_d   = width_inc;
          end
        end

        ST_REFRACT: begin
          // The strobe that brings the count to zero is the last ignored one;
          // the following strobe is compared in SEARCH.
          if (refr_q <= REFR_ONE) begin
            refr_d  = '0;
            state_d = ST_SEARCH;
          end else begin
            refr_d = refr_q - REFR_ONE;
          end
        end

        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  // State and datapath registers. Reset wins over enable in the same cycle,
  // which also discards any beat that was being tracked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      cur_max_q <= 32'd0;
      width_q   <= '0;
      refr_q    <= '0;
      rr_cnt_q  <= '0;
      peak_q    <= 32'd0;
      rr_int_q  <= '0;
      detect_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_max_q <= cur_max_d;
      width_q   <= width_d;
      refr_q    <= refr_d;
      rr_cnt_q  <= rr_cnt_d;
      peak_q    <= peak_d;
      rr_int_q  <= rr_int_d;
      detect_q  <= detect_d;
    end
  end

`ifdef QRS_ADAPTIVE_THR_EN
  logic [31:0] spk_q, spk_upd;
  logic [31:0] thr_q, thr_upd;

  // Running signal-peak estimate: spk moves one eighth of the way toward each
  // new beat peak, and the threshold sits at half of it but never below the
  // floor. Peaks are at most 2^31-1, so spk stays well inside 32 bits.
  always_comb begin
    spk_upd = spk_q - (spk_q >> 3) + (track_peak >> 3);
    thr_upd = ((spk_upd >> 1) > THRESH_MIN) ? (spk_upd >> 1) : THRESH_MIN;
  end

  // The adapted threshold is registered with the detect pulse, so the first
  // sample to see it is the strobe after the detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      spk_q <= THRESH_INIT << 1;
      thr_q <= THRESH_INIT;
    end else if (detect_d) begin
      spk_q <= spk_upd;
      thr_q <= thr_upd;
    end
  end

  assign thr_cur = thr_q;
`else
  assign thr_cur = THRESH_INIT;
`endif

  assign qrs_detect  = detect_q;
  assign peak_value  = peak_q;
  assign rr_interval = rr_int_q;
  assign threshold   = thr_cur;

endmodule

// File: tb/tb_qrs_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_qrs_peak_detector
//
// Scoreboard bench for qrs_peak_detector. The stimulus side feeds every
// strobed sample into a sample-indexed reference model; when the model sees a
// beat end it queues the expected peak, R-R interval and threshold. A separate
// monitor pops one entry per qrs_detect pulse and compares. Directed sections
// reproduce the documented scenarios, then a randomized section with gapped
// enables stresses the same model.
// ---------------------------------------------------------------------------
module tb_qrs_peak_detector;

  localparam logic [31:0] THRESH_INIT = 32'd2000;
  localparam logic [31:0] THRESH_MIN  = 32'd500;
  localparam int          REFRACT     = 50;
  localparam int          MAX_QRS     = 40;
  localparam int          RR_W        = 16;
  localparam longint      MAG_MAX     = 64'd2147483647;
  localparam longint      RR_MAX      = (64'd1 << RR_W) - 1;

  logic               clk;
  logic               reset;
  logic               enable;
  logic signed [31:0] filtered_ecg;
  logic               qrs_detect;
  logic [31:0]        peak_value;
  logic [RR_W-1:0]    rr_interval;
  logic [31:0]        threshold;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushes = 0;

  longint exp_peak_q[$];
  longint exp_rr_q[$];
  longint exp_thr_q[$];

  // Reference model state, expressed in strobe indices rather than states:
  // m_n counts strobes since reset, m_last is the strobe index of the last
  // detection, m_from is the first strobe allowed to start a new beat.
  longint m_n, m_last, m_from, m_len, m_peak, m_thr, m_spk;
  bit     m_run;

  qrs_peak_detector #(
    .THRESH_INIT (THRESH_INIT),
    .THRESH_MIN  (THRESH_MIN),
    .REFRACT     (REFRACT),
    .MAX_QRS     (MAX_QRS),
    .RR_W        (RR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .filtered_ecg (filtered_ecg),
    .qrs_detect   (qrs_detect),
    .peak_value   (peak_value),
    .rr_interval  (rr_interval),
    .threshold    (threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends even if the DUT wedges.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 800000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_n    = 0;
    m_last = 0;
    m_from = 1;
    m_run  = 1'b0;
    m_len  = 0;
    m_peak = 0;
    m_thr  = longint'(THRESH_INIT);
    m_spk  = 2 * longint'(THRESH_INIT);
  endtask

  task automatic model_step(input logic signed [31:0] x);
    longint mag;
    longint pk;
    longint rr;
    bit     det;
    mag = longint'(x);
    if (mag < 0) mag = -mag;
    if (mag > MAG_MAX) mag = MAG_MAX;
    m_n++;
    det = 1'b0;
    if (m_n < m_from) return;
    if (!m_run) begin
      if (mag > m_thr) begin
        m_run  = 1'b1;
        m_len  = 1;
        m_peak = mag;
      end
    end else begin
      if (mag <= m_thr) begin
        det = 1'b1;
      end else begin
        m_len++;
        if (mag > m_peak) m_peak = mag;
        if (m_len >= MAX_QRS) det = 1'b1;
      end
      if (det) begin
        pk = (mag > m_peak) ? mag : m_peak;
        rr = m_n - m_last;
        if (rr > RR_MAX) rr = RR_MAX;
        m_last = m_n;
        m_from = m_n + REFRACT + 1;
        m_run  = 1'b0;
`ifdef QRS_ADAPTIVE_THR_EN
        m_spk = m_spk - m_spk / 8 + pk / 8;
        m_thr = (m_spk / 2 > longint'(THRESH_MIN)) ? m_spk / 2 : longint'(THRESH_MIN);
`endif
        exp_peak_q.push_back(pk);
        exp_rr_q.push_back(rr);
        exp_thr_q.push_back(m_thr);
        pushes++;
      end
    end
  endtask

  // Drive one cycle of input; strobed samples go through the model as well.
  task automatic apply_stimulus(input logic signed [31:0] x, input bit en);
    @(negedge clk);
    filtered_ecg = x;
    enable       = en;
    if (en) model_step(x);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(32'sd0, 1'b0);
  endtask

  task automatic strobes(input logic signed [31:0] x, input int n);
    repeat (n) apply_stimulus(x, 1'b1);
  endtask

  // A strobe preceded by 0..3 idle cycles carrying junk data.
  task automatic gapped(input logic signed [31:0] x);
    repeat ($urandom_range(0, 3)) apply_stimulus(32'($urandom), 1'b0);
    apply_stimulus(x, 1'b1);
  endtask

  task automatic do_reset(input int cycles, input bit en, input logic signed [31:0] x);
    @(negedge clk);
    reset        = 1'b1;
    enable       = en;
    filtered_ecg = x;
    model_reset();
    repeat (cycles) @(negedge clk);
  endtask

  // Scoreboard monitor: one expected entry per pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (qrs_detect) begin
      pulses++;
      if (exp_peak_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: qrs_detect=1 with peak_value=%0d, expected no detection (t=%0t)",
                 peak_value, $time);
      end else begin
        check_output("pulse_peak_value", longint'(peak_value), exp_peak_q.pop_front());
        check_output("pulse_rr_interval", longint'(rr_interval), exp_rr_q.pop_front());
        check_output("pulse_threshold", longint'(threshold), exp_thr_q.pop_front());
      end
    end
  end

  initial begin
    logic signed [31:0] beat1 [6];
    int a;
    int len;
    beat1[0] = 32'sd0;     beat1[1] = 32'sd0;    beat1[2] = 32'sd3000;
    beat1[3] = -32'sd6000; beat1[4] = 32'sd4000; beat1[5] = 32'sd100;

    reset        = 1'b1;
    enable       = 1'b0;
    filtered_ecg = 32'sd0;
    model_reset();

    // Reset held with a live, above-threshold input
    do_reset(3, 1'b1, 32'sd5000);
    check_output("reset_qrs_detect", longint'(qrs_detect), 0);
    check_output("reset_peak_value", longint'(peak_value), 0);
    check_output("reset_rr_interval", longint'(rr_interval), 0);
    check_output("reset_threshold", longint'(threshold), longint'(THRESH_INIT));
    reset  = 1'b0;
    enable = 1'b0;

    // Single beat: detection on the strobe carrying 100
    foreach (beat1[i]) apply_stimulus(beat1[i], 1'b1);
    idle(2);
    check_output("beat1_peak_value", longint'(peak_value), 6000);
    check_output("beat1_rr_interval", longint'(rr_interval), 6);
    check_output("beat1_pulse_count", pulses, 1);
`ifndef QRS_ADAPTIVE_THR_EN
    check_output("beat1_threshold", longint'(threshold), 2000);
`endif

    // Refractory samples are ignored; second beat ends 60 strobes later
    strobes(32'sd5000, 10);
    check_output("refract_pulse_count", pulses, 1);
    strobes(32'sd0, 46);
    strobes(32'sd7000, 3);
    strobes(32'sd0, 1);
    idle(2);
    check_output("beat2_rr_interval", longint'(rr_interval), 60);
    check_output("beat2_peak_value", longint'(peak_value), 7000);
    check_output("beat2_pulse_count", pulses, 2);

    // Forced detection on the 40th above-threshold sample
    strobes(32'sd0, 50);
    strobes(32'sd9000, 45);
    idle(2);
    check_output("forced_peak_value", longint'(peak_value), 9000);
    check_output("forced_rr_interval", longint'(rr_interval), 90);
    check_output("forced_pulse_count", pulses, 3);
    strobes(32'sd0, 50);
    strobes(32'sd3000, 1);
    strobes(32'sd0, 1);
    idle(2);
    check_output("post_forced_pulse_count", pulses, 4);
    check_output("post_forced_rr_interval", longint'(rr_interval), 57);

    // Most negative input saturates the magnitude
    strobes(32'sd0, 50);
    apply_stimulus(32'sh8000_0000, 1'b1);
    strobes(32'sd0, 1);
    idle(2);
    check_output("minint_peak_value", longint'(peak_value), MAG_MAX);
    check_output("minint_pulse_count", pulses, 5);

    // Reset in the middle of TRACK discards the beat
    strobes(32'sd0, 50);
    strobes(32'sd5000, 1);
    strobes(32'sd6000, 1);
    do_reset(2, 1'b0, 32'sd0);
    reset = 1'b0;
    idle(3);
    check_output("midtrack_reset_pulse_count", pulses, 5);
    check_output("midtrack_reset_peak_value", longint'(peak_value), 0);

    // Gapped enable gives the same beat result
    foreach (beat1[i]) gapped(beat1[i]);
    idle(2);
    check_output("gapped_peak_value", longint'(peak_value), 6000);
    check_output("gapped_rr_interval", longint'(rr_interval), 6);
    check_output("gapped_pulse_count", pulses, 6);

`ifdef QRS_ADAPTIVE_THR_EN
    // Adaptation: peak 8000 from spk=4000 gives spk=4500, threshold 2250
    do_reset(2, 1'b0, 32'sd0);
    reset = 1'b0;
    strobes(32'sd0, 1);
    strobes(32'sd8000, 1);
    strobes(32'sd0, 1);
    idle(2);
    check_output("adapt_threshold_after_8000", longint'(threshold), 2250);
    // Small beats just above the threshold drag it down to the floor
    repeat (80) begin
      strobes(32'sd0, REFRACT);
      a = (m_thr + 1 > 600) ? int'(m_thr + 1) : 600;
      strobes(32'(a), 1);
      strobes(32'sd0, 1);
    end
    idle(2);
    check_output("adapt_threshold_floor", longint'(threshold), longint'(THRESH_MIN));
`endif

    // Randomized noise and bursts with random enable gaps
    do_reset(2, 1'b0, 32'sd0);
    reset = 1'b0;
    repeat (60) begin
      len = $urandom_range(5, 80);
      repeat (len) gapped(32'(int'($urandom_range(0, 3600)) - 1800));
      len = $urandom_range(1, 45);
      repeat (len) begin
        if ($urandom_range(0, 39) == 0) begin
          gapped(32'sh8000_0000);
        end else begin
          a = int'($urandom_range(2001, 100000));
          if ($urandom_range(0, 1) == 1) a = -a;
          gapped(32'(a));
        end
      end
    end
    strobes(32'sd0, 2);
    idle(3);
`ifndef QRS_ADAPTIVE_THR_EN
    check_output("random_threshold_constant", longint'(threshold), longint'(THRESH_INIT));
`endif
    check_output("pending_expected", longint'(exp_peak_q.size()), 0);
    check_output("total_pulses", pulses, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
